// File: rtl/fft_twiddle_mult_ctrl.sv
// fft_twiddle_mult_ctrl
// ---------------------------------------------------------------------------
// Sits between the two radix-2 butterfly stages of a 16-point radix-2^2 SDF
// FFT and applies the inter-stage twiddle W16^e to each sample. A shared,
// external combinational complex multiplier is used only for non-trivial
// twiddles. W^0 is a bypass and W^4 (= -j) is a swap plus a saturating negate.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start, stop              control pulses (stop drains the current frame)
//   in_valid/in_ready        input stream handshake
//   in_sop, in_re, in_im     input sample and start-of-frame marker
//   out_valid/out_ready      output stream handshake
//   out_sop, out_eop         result is frame index 0 / frame index 15
//   out_re, out_im           twiddled result (registered)
//   busy, sop_err            activity flag, sticky misplaced-SOP flag
//   mul_in_*, mul_enable     operands/enable to the external multiplier
//   mul_out_re, mul_out_im   multiplier result (same cycle)
//   state_dbg                current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer holds valid and its data until the transfer happens; ready may
// depend combinationally on the consumer's ready (in_ready uses out_ready).
// ---------------------------------------------------------------------------
module fft_twiddle_mult_ctrl #(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sop,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    busy,
  output logic                    sop_err,
  output logic signed [WIDTH-1:0] mul_in_one_re,
  output logic signed [WIDTH-1:0] mul_in_one_im,
  output logic signed [WIDTH-1:0] mul_in_two_re,
  output logic signed [WIDTH-1:0] mul_in_two_im,
  output logic                    mul_enable,
  input  logic signed [WIDTH-1:0] mul_out_re,
  input  logic signed [WIDTH-1:0] mul_out_im,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Twiddle magnitudes, rounded to nearest at the chosen fractional width.
  localparam real SCALE = 2.0 ** FIXED_POINT;
  localparam int  TW_A  = $rtoi(0.9238795325112867 * SCALE + 0.5); // cos(pi/8)
  localparam int  TW_B  = $rtoi(0.7071067811865476 * SCALE + 0.5); // cos(pi/4)
  localparam int  TW_C  = $rtoi(0.3826834323650898 * SCALE + 0.5); // sin(pi/8)

  localparam logic signed [WIDTH-1:0] POS_A = WIDTH'(TW_A);
  localparam logic signed [WIDTH-1:0] NEG_A = WIDTH'(-TW_A);
  localparam logic signed [WIDTH-1:0] POS_B = WIDTH'(TW_B);
  localparam logic signed [WIDTH-1:0] NEG_B = WIDTH'(-TW_B);
  localparam logic signed [WIDTH-1:0] POS_C = WIDTH'(TW_C);
  localparam logic signed [WIDTH-1:0] NEG_C = WIDTH'(-TW_C);

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  // Negation that maps the most negative value to the most positive one.
  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
    return (x == MIN_VAL) ? MAX_VAL : -x;
  endfunction

  state_e                  state_q;
  logic [3:0]              idx_q;
  logic                    out_valid_q, out_sop_q, out_eop_q, sop_err_q;
  logic signed [WIDTH-1:0] out_re_q, out_im_q;

  logic                    accept;
  logic [3:0]              eff_idx, idx_d, e;
  logic [1:0]              g, p;
  logic signed [WIDTH-1:0] tw_re, tw_im, res_re, res_im;

  assign in_ready = (state_q != IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    accept  = in_valid && in_ready;
    // An SOP forces the sample onto frame index 0 regardless of the counter.
    eff_idx = in_sop ? 4'd0 : idx_q;
    idx_d   = accept ? (eff_idx + 4'd1) : idx_q;
    // Radix-2^2 twiddle exponent: bit-reversed upper pair times lower pair.
    g       = {eff_idx[2], eff_idx[3]};
    p       = eff_idx[1:0];
    e       = {2'b00, g} * {2'b00, p};

    tw_re = '0;
    tw_im = '0;
    case (e)
      4'd1:    begin tw_re = POS_A; tw_im = NEG_C; end
      4'd2:    begin tw_re = POS_B; tw_im = NEG_B; end
      4'd3:    begin tw_re = POS_C; tw_im = NEG_A; end
      4'd6:    begin tw_re = NEG_B; tw_im = NEG_B; end
      4'd9:    begin tw_re = NEG_A; tw_im = POS_C; end
      default: begin tw_re = '0;    tw_im = '0;    end
    endcase

    mul_enable    = 1'b0;
    mul_in_one_re = '0;
    mul_in_one_im = '0;
    mul_in_two_re = '0;
    mul_in_two_im = '0;
    res_re        = in_re;
    res_im        = in_im;
    if (e == 4'd4) begin
      // Multiply by -j: (re + j im)(-j) = im - j re.
      res_re = in_im;
      res_im = neg_sat(in_re);
    end else if (e != 4'd0) begin
      res_re = mul_out_re;
      res_im = mul_out_im;
      // Multiplier inputs stay quiet unless a sample is really taken.
      if (accept) begin
        mul_enable    = 1'b1;
        mul_in_one_re = in_re;
        mul_in_one_im = in_im;
        mul_in_two_re = tw_re;
        mul_in_two_im = tw_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sop_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (start && !stop) state_q <= RUN;
        // Stopping on a frame boundary needs no drain.
        RUN:     if (stop) state_q <= (idx_d == 4'd0) ? IDLE : DRAIN;
        DRAIN: begin
          if (start)                            state_q <= RUN;
          else if (accept && eff_idx == 4'd15)  state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      idx_q <= idx_d;
      if (accept && in_sop && idx_q != 4'd0) sop_err_q <= 1'b1;

      if (accept) begin
        out_valid_q <= 1'b1;
        out_re_q    <= res_re;
        out_im_q    <= res_im;
        out_sop_q   <= (eff_idx == 4'd0);
        out_eop_q   <= (eff_idx == 4'd15);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign sop_err   = sop_err_q;
  assign busy      = (state_q != IDLE) || out_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_twiddle_mult_ctrl.sv
// Directed testbench for fft_twiddle_mult_ctrl, including a behavioural
// model of the external combinational complex multiplier (floor truncation).
module tb_fft_twiddle_mult_ctrl;

  localparam int W  = 16;
  localparam int FP = 11;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DRAIN = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start, stop, in_valid, in_ready, in_sop;
  logic signed [W-1:0] in_re, in_im;
  logic                out_valid, out_ready, out_sop, out_eop;
  logic signed [W-1:0] out_re, out_im;
  logic                busy, sop_err, mul_enable;
  logic signed [W-1:0] mul_in_one_re, mul_in_one_im, mul_in_two_re, mul_in_two_im;
  logic signed [W-1:0] mul_out_re, mul_out_im;
  logic [1:0]          state_dbg;

  fft_twiddle_mult_ctrl #(.WIDTH(W), .FIXED_POINT(FP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_re(out_re), .out_im(out_im),
    .busy(busy), .sop_err(sop_err),
    .mul_in_one_re(mul_in_one_re), .mul_in_one_im(mul_in_one_im),
    .mul_in_two_re(mul_in_two_re), .mul_in_two_im(mul_in_two_im),
    .mul_enable(mul_enable), .mul_out_re(mul_out_re), .mul_out_im(mul_out_im),
    .state_dbg(state_dbg)
  );

  // External multiplier: full-precision complex product, arithmetic shift.
  logic signed [31:0] prod_re, prod_im;
  always_comb begin
    prod_re    = 32'(mul_in_one_re) * 32'(mul_in_two_re) - 32'(mul_in_one_im) * 32'(mul_in_two_im);
    prod_im    = 32'(mul_in_one_re) * 32'(mul_in_two_im) + 32'(mul_in_one_im) * 32'(mul_in_two_re);
    mul_out_re = W'(prod_re >>> FP);
    mul_out_im = W'(prod_im >>> FP);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard for streamed transfers (packed {re, im}).
  logic [31:0] exp_q[$];
  logic        sb_en = 1'b0;
  int          sb_pops = 0;

  always begin
    @(negedge clk);
    #3;
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_transfer", int'({out_re, out_im}), -1);
      end else begin
        check("sb_data", int'({out_re, out_im}), int'(exp_q.pop_front()));
        sb_pops++;
      end
    end
  end

  // Multiplier-side values captured in the accept cycle.
  logic                acc_mul_en;
  logic signed [W-1:0] acc_m1re, acc_m2re, acc_m2im;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse(input logic s_start, input logic s_stop);
    @(negedge clk);
    start = s_start; stop = s_stop;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  // One accepted sample; returns #1 after the accepting edge.
  task automatic drive(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input logic sop);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_re = re; in_im = im; in_sop = sop;
    #1;
    while (!in_ready && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
    acc_mul_en = mul_enable;
    acc_m1re   = mul_in_one_re;
    acc_m2re   = mul_in_two_re;
    acc_m2im   = mul_in_two_im;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) drive(16'sd1, 16'sd1, 1'b0);
  endtask

  // Hand-computed frame of (1000, 0) samples, indices 0..15.
  int f_re[16] = '{1000, 1000, 1000, 1000, 1000, 707, 0, -708,
                   1000, 923, 707, 382, 1000, 382, -708, -924};
  int f_im[16] = '{0, 0, 0, 0, 0, -708, -1000, -708,
                   0, -383, -708, -924, 0, -924, -708, 382};
  int f_en[16] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1};

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_sop_err", int'(sop_err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_dbg), ST_IDLE);
    @(negedge clk); rst = 1'b1;

    // Full frame of (1000, 0)
    pulse(1'b1, 1'b0);
    check("start_state", int'(state_dbg), ST_RUN);
    for (int k = 0; k < 16; k++) begin
      drive(16'sd1000, 16'sd0, k == 0);
      check($sformatf("f_valid[%0d]", k), int'(out_valid), 1);
      check($sformatf("f_re[%0d]", k), int'(out_re), f_re[k]);
      check($sformatf("f_im[%0d]", k), int'(out_im), f_im[k]);
      check($sformatf("f_mul_en[%0d]", k), int'(acc_mul_en), f_en[k]);
      check($sformatf("f_sop[%0d]", k), int'(out_sop), int'(k == 0));
      check($sformatf("f_eop[%0d]", k), int'(out_eop), int'(k == 15));
      if (k == 5) begin
        check("f_tw_re[5]", int'(acc_m2re), 1448);
        check("f_tw_im[5]", int'(acc_m2im), -1448);
      end
    end

    // -j path at index 6
    do_reset();
    pulse(1'b1, 1'b0);
    advance(6);
    drive(16'sd300, -16'sd500, 1'b0);
    check("mj_re", int'(out_re), -500);
    check("mj_im", int'(out_im), -300);
    check("mj_mul_en", int'(acc_mul_en), 0);
    advance(15);
    drive(-16'sd32768, 16'sd0, 1'b0);
    check("mj_sat_re", int'(out_re), 0);
    check("mj_sat_im", int'(out_im), 32767);
    check("mj_sat_mul_in", int'(acc_m1re), 0);

    // Backpressure and back-to-back transfers
    do_reset();
    pulse(1'b1, 1'b0);
    exp_q.push_back({16'd100, 16'd0});
    exp_q.push_back({16'd200, 16'd1});
    exp_q.push_back({16'd300, 16'd2});
    exp_q.push_back({16'd400, 16'd3});
    sb_en = 1'b1;
    out_ready = 1'b0;
    drive(16'sd100, 16'sd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("bp_in_ready[%0d]", k), int'(in_ready), 0);
      check($sformatf("bp_valid[%0d]", k), int'(out_valid), 1);
      check($sformatf("bp_hold_re[%0d]", k), int'(out_re), 100);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_re = 16'sd200; in_im = 16'sd1; in_sop = 1'b0;
    #1;
    check("bp_ready_back", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(16'sd300, 16'sd2, 1'b0);
    drive(16'sd400, 16'sd3, 1'b0);
    repeat (3) @(negedge clk);
    #4;
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_pops", sb_pops, 4);
    sb_en = 1'b0;

    // Stop / drain
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("stop_idx0_state", int'(state_dbg), ST_IDLE);
    pulse(1'b1, 1'b1);
    check("start_stop_state", int'(state_dbg), ST_IDLE);
    pulse(1'b1, 1'b0);
    advance(7);
    pulse(1'b0, 1'b1);
    check("drain_state", int'(state_dbg), ST_DRAIN);
    check("drain_in_ready", int'(in_ready), 1);
    advance(8);
    check("drain_state_14", int'(state_dbg), ST_DRAIN);
    drive(16'sd7, 16'sd7, 1'b0);
    check("drain_done_state", int'(state_dbg), ST_IDLE);
    check("drain_done_eop", int'(out_eop), 1);
    check("drain_done_busy", int'(busy), 1);
    check("drain_done_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_out_valid", int'(out_valid), 0);
    pulse(1'b1, 1'b0);
    advance(3);
    pulse(1'b0, 1'b1);
    check("drain2_state", int'(state_dbg), ST_DRAIN);
    pulse(1'b1, 1'b0);
    check("drain_restart_state", int'(state_dbg), ST_RUN);

    // Misplaced SOP
    do_reset();
    pulse(1'b1, 1'b0);
    drive(16'sd1000, 16'sd0, 1'b1);
    advance(8);
    check("sop_err_clean", int'(sop_err), 0);
    drive(16'sd1000, 16'sd0, 1'b1);
    check("sop_err_set", int'(sop_err), 1);
    check("sop_pass_re", int'(out_re), 1000);
    check("sop_pass_im", int'(out_im), 0);
    check("sop_pass_mul_en", int'(acc_mul_en), 0);
    check("sop_pass_sop", int'(out_sop), 1);
    drive(16'sd1000, 16'sd0, 1'b0);
    check("sop_next_sop", int'(out_sop), 0);
    advance(4);
    drive(16'sd1000, 16'sd0, 1'b0);
    check("sop_idx6_re", int'(out_re), 0);
    check("sop_idx6_im", int'(out_im), -1000);
    check("sop_err_sticky", int'(sop_err), 1);

    // Reset in mid-frame
    do_reset();
    pulse(1'b1, 1'b0);
    drive(16'sd5, 16'sd5, 1'b1);
    drive(16'sd5, 16'sd5, 1'b1);
    advance(9);
    check("mid_pre_sop_err", int'(sop_err), 1);
    check("mid_pre_valid", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_re", int'(out_re), 0);
    check("mid_rst_sop_err", int'(sop_err), 0);
    check("mid_rst_state", int'(state_dbg), ST_IDLE);
    @(negedge clk); rst = 1'b1;
    pulse(1'b1, 1'b0);
    drive(16'sd300, -16'sd500, 1'b0);
    check("mid_after_sop", int'(out_sop), 1);
    check("mid_after_re", int'(out_re), 300);
    check("mid_after_im", int'(out_im), -500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_twiddle_mult_ctrl.md
Name: fft_twiddle_mult_ctrl

Overview:
- Sequences the shared combinational complex multiplier between the two radix-2 butterfly stages of the 16-point radix-2² SDF FFT.
- Tracks each sample's index within its 16-sample frame and selects the twiddle W16^e from an internal constant table.
- Drives the multiplier, or bypasses it when the twiddle is trivial, and registers the result behind a valid/ready stream interface.

Parameters:
- WIDTH, 16, sample and twiddle word width (signed two's complement).
- FIXED_POINT, 11, fractional bits; twiddle 1.0 = 2^FIXED_POINT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin accepting samples.
- stop  in  1  pulse: finish the current frame, then go idle.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept a sample.
- in_sop  in  1  marks the first sample of a frame.
- in_re, in_im  in  WIDTH  input sample.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_sop, out_eop  out  1  result is frame index 0 / frame index 15.
- out_re, out_im  out  WIDTH  twiddled result.
- busy  out  1  state is not IDLE or out_valid=1.
- sop_err  out  1  sticky: in_sop was seen at a nonzero index.
- mul_in_one_re, mul_in_one_im  out  WIDTH  to multiplier: sample.
- mul_in_two_re, mul_in_two_im  out  WIDTH  to multiplier: twiddle.
- mul_enable  out  1  multiplier enable.
- mul_out_re, mul_out_im  in  WIDTH  multiplier result (combinational, same cycle).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, idx=0. out_valid, out_sop, out_eop and sop_err are 0. out_re and out_im are 0. A frame in flight is discarded.
- FSM states:
  - IDLE: on start with stop=0, go to RUN. Simultaneous start and stop leave the FSM in IDLE.
  - RUN: on stop, if idx=0 go to IDLE, else go to DRAIN.
  - DRAIN: go to IDLE when the idx=15 sample is accepted. A start in DRAIN returns to RUN, cancelling the stop.
- in_ready = (state != IDLE) && (!out_valid || out_ready).
- A sample is accepted when in_valid && in_ready.
- Index counter idx is 4 bits and advances on each accept, wrapping 15 to 0.
- in_sop on an accept forces the effective index to 0 for that sample, so the next idx is 1. If idx was nonzero at that point, sop_err is set and stays set until reset.
- Twiddle exponent: g = {idx[2], idx[3]}, p = idx[1:0], e = g*p (range 0..9).
- Twiddle table, W16^e = cos(2πe/16) − j·sin(2πe/16), values at FIXED_POINT=11:
  - e=1: (1892, −784)
  - e=2: (1448, −1448)
  - e=3: (784, −1892)
  - e=6: (−1448, −1448)
  - e=9: (−1892, 784)
  - For other FIXED_POINT values, use round(2^FP·cos) and round(−2^FP·sin).
- Path selection:
  - e=0: bypass; result = input.
  - e=4: multiply by −j; result = (in_im, −in_re). Negating −2^(WIDTH−1) saturates to 2^(WIDTH−1)−1.
  - Otherwise: mul_enable=1. mul_in_one = sample, mul_in_two = twiddle, result = mul_out.
- When there is no accept, or e is 0 or 4, mul_enable=0 and all mul_in_* ports are 0.
- Output register, latency 1: on accept, out_re/out_im/out_sop/out_eop load and out_valid=1.
  - out_eop = (effective index == 15).
  - out_valid clears on out_ready when no new accept occurs in the same cycle.
  - Accept and drain in the same cycle: the register reloads and out_valid stays 1.
- Output data holds stable while out_valid && !out_ready.
- No arithmetic beyond the multiplier's truncation, which is a floor via arithmetic shift.

Test Plan:
- Reset, start, then 16 samples of (1000,0) with in_sop on the first, out_ready=1. Idx 5 → (707, −708). Idx 4 → (1000, 0). Idx 9 → (923, −383). out_sop at idx 0, out_eop at idx 15. mul_enable is low at e=0 and e=4.
- At idx 6, input (300, −500) → output (−500, −300) with mul_enable=0. At idx 6, input re=−32768 → out_im = 32767.
- Hold out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and output stable. Then raise out_ready with in_valid=1 → back-to-back transfers, no loss or duplication.
- stop at idx 7 → state DRAIN; idx 8..15 are still accepted; then IDLE with in_ready=0. A start during DRAIN keeps the FSM in RUN.
- in_sop at idx 9 → sop_err=1, that sample uses e=0 and is passed through unchanged, the next sample uses idx 1.
- Assert rst at mid-frame idx 10 with out_valid=1 → out_valid=0, out_re=0, sop_err=0, FSM IDLE. After start, the next sample is treated as idx 0.
